pt5_trit_feeder: RTL
====================

Name: pt5_trit_feeder

Overview:
- Decoder and issuer that feeds a ternary lane ALU.
- Accepts paired PT-5 packed bytes over a valid/ready stream: one weight byte and one input byte, 5 trits each, base-3 offset-coded.
- Unpacks each pair into one trit pair per cycle in 2-bit simple encoding, driving a lane's weight, trit_in and enable.
- Sits between the lane's operand buffers and the lane ALU; frame boundaries are marked with last and tail-count.

Parameters:
- CNT_W, 32, width of trit_count and err_count.
- TRITS_PER_BYTE, 5, trits per packed byte; fixed, the only supported value.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_valid  in  1  byte pair valid
- s_ready  out  1  byte pair accepted when s_valid&s_ready at a rising edge
- s_weight_byte  in  8  packed weight trits
- s_input_byte  in  8  packed input trits
- s_last  in  1  final byte pair of frame
- s_tail_trits  in  3  valid trits in last pair, 1..5; ignored when s_last=0
- stall  in  1  lane hold; no trit issued at an edge while high
- weight  out  2  trit to lane (00=0, 01=+1, 10=-1)
- trit_in  out  2  trit to lane
- enable  out  1  lane enable, high for exactly one cycle per issued trit pair
- frame_done  out  1  one-cycle pulse after the last trit of a frame is issued
- decode_err  out  1  sticky: a byte value >242 was received
- trit_count  out  CNT_W  trit pairs issued since reset, wraps modulo 2^CNT_W
- err_count  out  CNT_W  byte pairs with at least one invalid byte, wraps

Behaviour:
- Reset (async) clears every output to 0, state to IDLE, and discards any partially issued byte. Reset wins over any simultaneous accept.
- Coding: byte = sum over i=0..4 of d_i·3^i, d_i in {0,1,2}. Trit i = d_i−1, so d=0→10, d=1→00, d=2→01. Trit 0 (LSD) is issued first.
- Invalid byte (>242): every trit of that byte is decoded as 00. decode_err is set and stays set until reset. err_count increments once per accepted pair in which either byte is invalid. The other byte of the pair still decodes normally.
- Tail count: n = s_tail_trits if s_last=1 and 1≤s_tail_trits≤5; otherwise n=5.
- State IDLE: s_ready=1. On accept, latch both bytes, n, and the last flag; set idx=0; go to SHIFT. Outputs are unchanged and enable=0 at the accept edge.
- State SHIFT: at each edge with stall=0:
  - register decode(w_rem mod 3) onto weight and decode(x_rem mod 3) onto trit_in;
  - set enable=1;
  - w_rem←w_rem/3, x_rem←x_rem/3, idx++;
  - increment trit_count.
- State SHIFT with stall=1: hold weight, trit_in, idx and remainders; enable←0.
- Latency: accept at edge E0 → trit i appears at edge E(1+i) if there are no stalls.
- s_ready in SHIFT = (idx==n−1) && !stall. This gives back-to-back pairs at 1 trit/cycle with no bubble.
- Final trit of a pair issued at edge E:
  - if an accept also occurs at E, reload the registers with idx=0 and stay in SHIFT;
  - otherwise go to IDLE and enable←0 at the next edge.
- frame_done is registered and high for the one cycle after the edge that issued the final trit of a pair latched with s_last=1.
- weight and trit_in hold their last values while idle.
- s_* inputs are sampled only at the accept edge; changes at other times are ignored.

Decomposition:
- Package pt5_pkg:
  - trit encoding constants TRIT_ZERO=2'b00, TRIT_POS=2'b01, TRIT_NEG=2'b10;
  - PT5_MAX=242, TRITS_PER_BYTE=5;
  - state enum {IDLE, SHIFT};
  - function digit_to_trit.
- Sub-module pt5_divmod3: combinational 8-bit /3 and mod 3. Instantiated twice, once per operand stream.

Test Plan:
- Pair (121,121), s_last=1, tail 5 → 5 cycles of weight=00, trit_in=00, enable=1; frame_done one cycle after trit 4; trit_count=5.
- Pair (242,0) → weight=01 ×5 and trit_in=10 ×5; (65,65) → trits +1,−1,0,+1,−1, i.e. 01,10,00,01,10, in that order.
- s_valid held high with two pairs → 10 consecutive enable cycles; s_ready high exactly 1 cycle in 5; second pair's trit 0 follows first pair's trit 4 with no gap.
- Pair (250,242) → weight 00 ×5, trit_in 01 ×5, decode_err=1, err_count=1; decode_err still 1 after the next valid pair.
- s_last=1 with tail 3 on (65,65) → 3 enables (01,10,00), frame_done pulse, back to IDLE with s_ready=1; tail 0 → 5 trits issued.
- stall high for 2 cycles after trit 1 → enable low for 2 cycles, outputs hold 10, trits 2..4 resume; reset asserted mid-byte → all outputs 0, s_ready=1, no further enables.

Source files
------------

// File: rtl/pt5_pkg.sv
// Shared constants, state type and trit helper for the PT-5 trit feeder.
// The feeder unpacks base-3 offset-coded bytes into 2-bit lane trits.
package pt5_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam logic [7:0] PT5_MAX        = 8'd242;
  // Five digits of 1 (11111 in base 3): every trit decodes to zero.
  localparam logic [7:0] PT5_ZERO_BYTE  = 8'd121;
  localparam int         TRITS_PER_BYTE = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [1:0] digit_to_trit(input logic [1:0] d);
    case (d)
      2'd0:    return TRIT_NEG;
      2'd1:    return TRIT_ZERO;
      2'd2:    return TRIT_POS;
      default: return TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pt5_divmod3.sv
// Combinational divide-by-3 and modulo-3 of an 8-bit operand.
// One instance per operand stream peels off the least significant base-3 digit.
module pt5_divmod3 (
  input  logic [7:0] a,
  output logic [7:0] q,
  output logic [1:0] r
);

  assign q = a / 8'd3;
  assign r = 2'(a % 8'd3);

endmodule

// File: rtl/pt5_trit_feeder.sv
// Accepts PT-5 weight/input byte pairs and issues one trit pair per cycle to a lane.
// state | meaning
// IDLE  | no byte pair held; s_ready high, outputs hold last trits
// SHIFT | issuing trits of the held pair, LSD first, one per unstalled edge
module pt5_trit_feeder
  import pt5_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TRITS_PER_BYTE = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_weight_byte,
  input  logic [7:0]       s_input_byte,
  input  logic             s_last,
  input  logic [2:0]       s_tail_trits,
  input  logic             stall,
  output logic [1:0]       weight,
  output logic [1:0]       trit_in,
  output logic             enable,
  output logic             frame_done,
  output logic             decode_err,
  output logic [CNT_W-1:0] trit_count,
  output logic [CNT_W-1:0] err_count
);

  state_t     state, state_next;
  logic [7:0] w_rem, x_rem, w_div, x_div;
  logic [1:0] w_mod, x_mod;
  logic [2:0] idx, n_q, tail_n;
  logic       last_q;
  logic       issue, final_trit, accept, w_bad, x_bad;

  pt5_divmod3 u_div_w (.a(w_rem), .q(w_div), .r(w_mod));
  pt5_divmod3 u_div_x (.a(x_rem), .q(x_div), .r(x_mod));

  assign w_bad      = s_weight_byte > PT5_MAX;
  assign x_bad      = s_input_byte > PT5_MAX;
  assign final_trit = (idx == n_q - 3'd1);
  assign issue      = (state == SHIFT) && !stall;
  // Ready on the final trit lets the next pair load with no bubble.
  assign s_ready    = (state == IDLE) || (issue && final_trit);
  assign accept     = s_valid && s_ready;

  always_comb begin
    tail_n = 3'(TRITS_PER_BYTE);
    if (s_last && (s_tail_trits >= 3'd1) && (s_tail_trits <= 3'(TRITS_PER_BYTE)))
      tail_n = s_tail_trits;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (issue && final_trit && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_rem      <= '0;
      x_rem      <= '0;
      idx        <= '0;
      n_q        <= '0;
      last_q     <= 1'b0;
      weight     <= TRIT_ZERO;
      trit_in    <= TRIT_ZERO;
      enable     <= 1'b0;
      frame_done <= 1'b0;
      decode_err <= 1'b0;
      trit_count <= '0;
      err_count  <= '0;
    end else begin
      enable     <= 1'b0;
      frame_done <= 1'b0;
      if (issue) begin
        weight     <= digit_to_trit(w_mod);
        trit_in    <= digit_to_trit(x_mod);
        enable     <= 1'b1;
        w_rem      <= w_div;
        x_rem      <= x_div;
        idx        <= idx + 3'd1;
        trit_count <= trit_count + CNT_W'(1);
        if (final_trit) frame_done <= last_q;
      end
      // A load in the same edge as the final trit overrides the shift update.
      if (accept) begin
        w_rem  <= w_bad ? PT5_ZERO_BYTE : s_weight_byte;
        x_rem  <= x_bad ? PT5_ZERO_BYTE : s_input_byte;
        n_q    <= tail_n;
        last_q <= s_last;
        idx    <= '0;
        if (w_bad || x_bad) begin
          decode_err <= 1'b1;
          err_count  <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
